// File: rtl/audio_pkg.sv
// Shared pan codes and mixer FSM state type for the audio datapath.
package audio_pkg;

   localparam logic [1:0] PAN_MUTE   = 2'b00;
   localparam logic [1:0] PAN_RIGHT  = 2'b01;
   localparam logic [1:0] PAN_LEFT   = 2'b10;
   localparam logic [1:0] PAN_CENTRE = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StOutput
   } mix_state_e;

endpackage

// File: rtl/sat_clip.sv
// Signed saturating narrower: clamps a wide signed value into OUT_W bits.
module sat_clip #(
   parameter int unsigned IN_W  = 19,
   parameter int unsigned OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  data_i,
   output logic signed [OUT_W-1:0] data_o
);

   localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      if (data_i > MAX_V) begin
         data_o = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (data_i < MIN_V) begin
         data_o = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         data_o = data_i[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/stereo_mixer.sv
// Sequential stereo/mono voice mixer: one channel accumulated per cycle, saturated output.
module stereo_mixer
   import audio_pkg::*;
#(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned SHIFT    = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
   input  logic [2*NUM_CH-1:0]          pan_in,
   input  logic                         stereo_on,
   input  logic                         sample_valid_in,
   output logic                         ready_out,
   output logic signed [SAMPLE_W-1:0]   sample_l,
   output logic signed [SAMPLE_W-1:0]   sample_r,
   output logic                         sample_valid_out,
   output logic                         overrun_out
);

   localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
   localparam int unsigned CNT_W = $clog2(NUM_CH);
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

   mix_state_e                   state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [NUM_CH*SAMPLE_W-1:0]   samp_q, samp_d;
   logic [2*NUM_CH-1:0]          pan_q, pan_d;
   logic                         stereo_q, stereo_d;
   logic signed [ACC_W-1:0]      acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic                         flush_q, flush_d;
   logic                         valid_q, valid_d;
   logic signed [SAMPLE_W-1:0]   sample_l_q, sample_l_d, sample_r_q, sample_r_d;
   logic                         overrun_q, overrun_d;

   logic signed [SAMPLE_W-1:0]   cur_s;
   logic [1:0]                   cur_pan;
   logic signed [ACC_W-1:0]      s_ext, s_half, add_l, add_r;
   logic signed [ACC_W-1:0]      shift_l, shift_r;
   logic signed [SAMPLE_W-1:0]   sat_l, sat_r;

   assign cur_s   = samp_q[32'(cnt_q) * SAMPLE_W +: SAMPLE_W];
   assign cur_pan = pan_q[32'(cnt_q) * 2 +: 2];
   assign s_ext   = {{(ACC_W-SAMPLE_W){cur_s[SAMPLE_W-1]}}, cur_s};
   assign s_half  = s_ext >>> 1;
   assign shift_l = acc_l_q >>> SHIFT;
   assign shift_r = acc_r_q >>> SHIFT;

   sat_clip #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_l (.data_i(shift_l), .data_o(sat_l));
   sat_clip #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_r (.data_i(shift_r), .data_o(sat_r));

   always_comb begin
      add_l = '0;
      add_r = '0;
      if (!stereo_q) begin
         if (cur_pan != PAN_MUTE) begin
            add_l = s_ext;
            add_r = s_ext;
         end
      end else begin
         unique case (cur_pan)
            PAN_LEFT:   add_l = s_ext;
            PAN_RIGHT:  add_r = s_ext;
            PAN_CENTRE: begin
               add_l = s_half;
               add_r = s_half;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      samp_d     = samp_q;
      pan_d      = pan_q;
      stereo_d   = stereo_q;
      acc_l_d    = acc_l_q;
      acc_r_d    = acc_r_q;
      flush_d    = 1'b0;
      valid_d    = 1'b0;
      sample_l_d = sample_l_q;
      sample_r_d = sample_r_q;
      overrun_d  = overrun_q | (sample_valid_in && (state_q != StIdle));

      // Results land one cycle after OUTPUT so the pulse coincides with the next accept slot.
      if (flush_q) begin
         sample_l_d = sat_l;
         sample_r_d = sat_r;
         valid_d    = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (sample_valid_in) begin
               samp_d   = sample_in;
               pan_d    = pan_in;
               stereo_d = stereo_on;
               acc_l_d  = '0;
               acc_r_d  = '0;
               cnt_d    = '0;
               state_d  = StAccum;
            end
         end
         StAccum: begin
            acc_l_d = acc_l_q + add_l;
            acc_r_d = acc_r_q + add_r;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CH) begin
               state_d = StOutput;
            end
         end
         StOutput: begin
            flush_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         samp_q     <= '0;
         pan_q      <= '0;
         stereo_q   <= 1'b0;
         acc_l_q    <= '0;
         acc_r_q    <= '0;
         flush_q    <= 1'b0;
         valid_q    <= 1'b0;
         sample_l_q <= '0;
         sample_r_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         samp_q     <= samp_d;
         pan_q      <= pan_d;
         stereo_q   <= stereo_d;
         acc_l_q    <= acc_l_d;
         acc_r_q    <= acc_r_d;
         flush_q    <= flush_d;
         valid_q    <= valid_d;
         sample_l_q <= sample_l_d;
         sample_r_q <= sample_r_d;
         overrun_q  <= overrun_d;
      end
   end

   assign ready_out        = (state_q == StIdle);
   assign sample_l         = sample_l_q;
   assign sample_r         = sample_r_q;
   assign sample_valid_out = valid_q;
   assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_stereo_mixer.sv
// Self-checking bench for stereo_mixer: directed scenarios plus randomized frames vs a model.
module tb_stereo_mixer;

   localparam int NCH = 3;

   logic               clk;
   logic               rst_in;
   logic [47:0]        sample_in;
   logic [5:0]         pan_in;
   logic               stereo_on;
   logic               sample_valid_in;
   logic               ready_out, sample_valid_out, overrun_out;
   logic signed [15:0] sample_l, sample_r;
   logic               rdy0, v0, ov0;
   logic signed [15:0] l0, r0;

   int errors = 0;
   int checks = 0;

   stereo_mixer #(.NUM_CH(3), .SAMPLE_W(16), .SHIFT(2)) dut (
      .clk_in(clk), .rst_in(rst_in), .sample_in(sample_in), .pan_in(pan_in),
      .stereo_on(stereo_on), .sample_valid_in(sample_valid_in), .ready_out(ready_out),
      .sample_l(sample_l), .sample_r(sample_r), .sample_valid_out(sample_valid_out),
      .overrun_out(overrun_out)
   );

   stereo_mixer #(.NUM_CH(3), .SAMPLE_W(16), .SHIFT(0)) dut0 (
      .clk_in(clk), .rst_in(rst_in), .sample_in(sample_in), .pan_in(pan_in),
      .stereo_on(stereo_on), .sample_valid_in(sample_valid_in), .ready_out(rdy0),
      .sample_l(l0), .sample_r(r0), .sample_valid_out(v0), .overrun_out(ov0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference mix: integer sums, floor shifts, clamp to 16-bit signed.
   task automatic model(input logic [47:0] smp, input logic [5:0] pan, input logic st,
                        input int sh, output int l, output int r);
      int sl, sr, s;
      logic [1:0] p;
      sl = 0;
      sr = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         s = int'($signed(smp[ch*16 +: 16]));
         p = pan[ch*2 +: 2];
         if (p != 2'b00) begin
            if (!st) begin
               sl += s;
               sr += s;
            end else if (p == 2'b10) begin
               sl += s;
            end else if (p == 2'b01) begin
               sr += s;
            end else begin
               sl += s / 2 - ((s < 0 && (s % 2) != 0) ? 1 : 0);
               sr += s / 2 - ((s < 0 && (s % 2) != 0) ? 1 : 0);
            end
         end
      end
      sl = sl >>> sh;
      sr = sr >>> sh;
      l = (sl > 32767) ? 32767 : (sl < -32768) ? -32768 : sl;
      r = (sr > 32767) ? 32767 : (sr < -32768) ? -32768 : sr;
   endtask

   // Presents one frame, scrambles inputs after acceptance, returns edges to the pulse (0 = none).
   task automatic do_frame(input logic [47:0] smp, input logic [5:0] pan, input logic st,
                           output int lat);
      @(negedge clk);
      sample_in       = smp;
      pan_in          = pan;
      stereo_on       = st;
      sample_valid_in = 1'b1;
      @(posedge clk);
      #1;
      sample_valid_in = 1'b0;
      sample_in       = {16'($urandom), 16'($urandom), 16'($urandom)};
      pan_in          = 6'($urandom);
      stereo_on       = ~st;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (sample_valid_out) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_in = 1'b1;
      sample_valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sample_l !== 16'sd0 || sample_r !== 16'sd0) begin
         errors++;
         $display("FAIL reset_outputs: got l=%0d r=%0d, want 0 0", sample_l, sample_r);
      end
      checks++;
      if (sample_valid_out !== 1'b0 || overrun_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got valid=%b overrun=%b, want 0 0",
                  sample_valid_out, overrun_out);
      end
      rst_in = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, want 1", ready_out);
      end
   endtask

   task automatic test_stereo;
      logic signed [15:0] hl, hr;
      int lat;
      do_frame({16'sd400, 16'sd2000, 16'sd1000}, {2'b11, 2'b01, 2'b10}, 1'b1, lat);
      checks++;
      if (lat != 5) begin
         errors++;
         $display("FAIL stereo_latency: got %0d edges, want 5", lat);
      end
      checks++;
      if (sample_l !== 16'sd300 || sample_r !== 16'sd550) begin
         errors++;
         $display("FAIL stereo_mix: got l=%0d r=%0d, want 300 550", sample_l, sample_r);
      end
      hl = sample_l;
      hr = sample_r;
      @(posedge clk);
      #1;
      checks++;
      if (sample_valid_out !== 1'b0 || sample_l !== hl || sample_r !== hr) begin
         errors++;
         $display("FAIL stereo_hold: got valid=%b l=%0d r=%0d, want 0 %0d %0d",
                  sample_valid_out, sample_l, sample_r, hl, hr);
      end
   endtask

   task automatic test_mono;
      int lat;
      do_frame({16'sd400, 16'sd2000, 16'sd1000}, {2'b11, 2'b01, 2'b10}, 1'b0, lat);
      checks++;
      if (lat != 5 || sample_l !== 16'sd850 || sample_r !== 16'sd850) begin
         errors++;
         $display("FAIL mono_mix: got lat=%0d l=%0d r=%0d, want 5 850 850",
                  lat, sample_l, sample_r);
      end
      do_frame({16'sd400, 16'sd2000, 16'sd1000}, {2'b11, 2'b00, 2'b10}, 1'b0, lat);
      checks++;
      if (lat != 5 || sample_l !== 16'sd350 || sample_r !== 16'sd350) begin
         errors++;
         $display("FAIL mono_mute: got lat=%0d l=%0d r=%0d, want 5 350 350",
                  lat, sample_l, sample_r);
      end
   endtask

   task automatic test_saturation;
      int lat;
      do_frame({16'sd30000, 16'sd30000, 16'sd30000}, 6'b101010, 1'b1, lat);
      checks++;
      if (lat != 5 || l0 !== 16'sd32767 || r0 !== 16'sd0) begin
         errors++;
         $display("FAIL sat_pos: got lat=%0d l=%0d r=%0d, want 5 32767 0", lat, l0, r0);
      end
      do_frame({-16'sd30000, -16'sd30000, -16'sd30000}, 6'b101010, 1'b1, lat);
      checks++;
      if (l0 !== -16'sd32768 || r0 !== 16'sd0) begin
         errors++;
         $display("FAIL sat_neg: got l=%0d r=%0d, want -32768 0", l0, r0);
      end
   endtask

   task automatic test_sign;
      int lat;
      do_frame({16'sd0, 16'sd0, -16'sd1}, {2'b00, 2'b00, 2'b10}, 1'b1, lat);
      checks++;
      if (lat != 5 || sample_l !== -16'sd1 || sample_r !== 16'sd0) begin
         errors++;
         $display("FAIL sign_shift: got lat=%0d l=%0d r=%0d, want 5 -1 0",
                  lat, sample_l, sample_r);
      end
   endtask

   task automatic test_overrun;
      int lat, pulses, el, er;
      logic [47:0] smp;
      logic [5:0]  pan;
      smp = {16'($urandom), 16'($urandom), 16'($urandom)};
      pan = 6'($urandom);
      model(smp, pan, 1'b1, 2, el, er);
      @(negedge clk);
      sample_in = smp;
      pan_in = pan;
      stereo_on = 1'b1;
      sample_valid_in = 1'b1;
      @(posedge clk);
      #1;
      sample_valid_in = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ready_out !== 1'b0) begin
         errors++;
         $display("FAIL overrun_ready: got %b, want 0", ready_out);
      end
      sample_in = ~smp;
      pan_in = ~pan;
      stereo_on = 1'b0;
      sample_valid_in = 1'b1;
      @(posedge clk);
      #1;
      sample_valid_in = 1'b0;
      checks++;
      if (overrun_out !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %b, want 1", overrun_out);
      end
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (sample_valid_out) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat != 3 || sample_l !== 16'(el) || sample_r !== 16'(er)) begin
         errors++;
         $display("FAIL overrun_first: got lat=%0d l=%0d r=%0d, want 3 %0d %0d",
                  lat, sample_l, sample_r, el, er);
      end
      pulses = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (sample_valid_out) pulses++;
      end
      checks++;
      if (pulses != 0 || overrun_out !== 1'b1) begin
         errors++;
         $display("FAIL overrun_ignored: got pulses=%0d overrun=%b, want 0 1",
                  pulses, overrun_out);
      end
      do_frame(smp, pan, 1'b1, lat);
      checks++;
      if (overrun_out !== 1'b1 || sample_l !== 16'(el)) begin
         errors++;
         $display("FAIL overrun_sticky: got overrun=%b l=%0d, want 1 %0d",
                  overrun_out, sample_l, el);
      end
   endtask

   task automatic test_reset_mid;
      int lat, pulses, el, er;
      logic [47:0] smp;
      @(negedge clk);
      sample_in = {16'sd1234, 16'sd5678, 16'sd999};
      pan_in = 6'b111111;
      stereo_on = 1'b1;
      sample_valid_in = 1'b1;
      @(posedge clk);
      #1;
      sample_valid_in = 1'b0;
      @(posedge clk);
      #1;
      rst_in = 1'b1;
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      checks++;
      if (ready_out !== 1'b1 || sample_l !== 16'sd0 || sample_r !== 16'sd0
          || overrun_out !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: got rdy=%b l=%0d r=%0d ov=%b, want 1 0 0 0",
                  ready_out, sample_l, sample_r, overrun_out);
      end
      pulses = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (sample_valid_out) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midreset_pulse: got %0d pulses, want 0", pulses);
      end
      smp = {16'($urandom), 16'($urandom), 16'($urandom)};
      model(smp, 6'b111001, 1'b1, 2, el, er);
      do_frame(smp, 6'b111001, 1'b1, lat);
      checks++;
      if (lat != 5 || sample_l !== 16'(el) || sample_r !== 16'(er)) begin
         errors++;
         $display("FAIL midreset_next: got lat=%0d l=%0d r=%0d, want 5 %0d %0d",
                  lat, sample_l, sample_r, el, er);
      end
   endtask

   task automatic test_random;
      int lat, el, er, el0, er0;
      logic [47:0] smp;
      logic [5:0]  pan;
      logic        st;
      for (int n = 0; n < 25; n++) begin
         smp = {16'($urandom), 16'($urandom), 16'($urandom)};
         if (n % 4 == 0) smp[15:0] = 16'sh8000;
         pan = 6'($urandom);
         st  = 1'($urandom);
         model(smp, pan, st, 2, el, er);
         model(smp, pan, st, 0, el0, er0);
         do_frame(smp, pan, st, lat);
         checks++;
         if (lat != 5 || sample_l !== 16'(el) || sample_r !== 16'(er)) begin
            errors++;
            $display("FAIL random_%0d: got lat=%0d l=%0d r=%0d, want 5 %0d %0d",
                     n, lat, sample_l, sample_r, el, er);
         end
         checks++;
         if (l0 !== 16'(el0) || r0 !== 16'(er0)) begin
            errors++;
            $display("FAIL random_sat_%0d: got l=%0d r=%0d, want %0d %0d",
                     n, l0, r0, el0, er0);
         end
      end
   endtask

   task automatic test_back_to_back;
      int ql[$], qr[$];
      int sent, got, last_t, el, er;
      logic [47:0] smp;
      logic [5:0]  pan;
      logic        st;
      sent = 0;
      got = 0;
      last_t = 0;
      for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
         @(negedge clk);
         if (ready_out && sent < 5) begin
            smp = {16'($urandom), 16'($urandom), 16'($urandom)};
            pan = 6'($urandom);
            st  = 1'($urandom);
            model(smp, pan, st, 2, el, er);
            ql.push_back(el);
            qr.push_back(er);
            sample_in = smp;
            pan_in = pan;
            stereo_on = st;
            sample_valid_in = 1'b1;
            sent++;
         end else begin
            sample_valid_in = 1'b0;
         end
         @(posedge clk);
         #1;
         if (sample_valid_out) begin
            el = (ql.size() > 0) ? ql.pop_front() : 99999;
            er = (qr.size() > 0) ? qr.pop_front() : 99999;
            checks++;
            if (sample_l !== 16'(el) || sample_r !== 16'(er) || el == 99999) begin
               errors++;
               $display("FAIL b2b_data_%0d: got l=%0d r=%0d, want %0d %0d",
                        got, sample_l, sample_r, el, er);
            end
            if (got > 0) begin
               checks++;
               if (cyc - last_t != 5) begin
                  errors++;
                  $display("FAIL b2b_spacing_%0d: got %0d cycles, want 5", got, cyc - last_t);
               end
            end
            last_t = cyc;
            got++;
         end
      end
      sample_valid_in = 1'b0;
      checks++;
      if (got != 5) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want 5", got);
      end
   endtask

   initial begin
      rst_in = 1'b1;
      sample_in = '0;
      pan_in = '0;
      stereo_on = 1'b0;
      sample_valid_in = 1'b0;
      test_reset();
      test_stereo();
      test_mono();
      test_saturation();
      test_sign();
      test_overrun();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
